matrix_cmd_fetch: RTL and testbench
===================================

# matrix_cmd_fetch

Command front-end for the matrix-multiply accelerator. It polls the control BRAM (port D) for a doorbell and fetches dimension descriptors from it. It validates each descriptor, issues one command per valid descriptor to the multiply core over a valid/ready handshake, and waits for the core's done pulse. When the batch finishes it writes a completion status word back to BRAM D. It sits directly upstream of the multiply core inside `accelerator_top` and owns BRAM port D exclusively.

## Interface
Parameters:
- `ADDR_W`, 9: BRAM D word-address width.
- `DIM_W`, 16: width of each dimension field.
- `MAX_DIM`, 256: largest legal value of M, K or N.
- `POLL_INTERVAL`, 16: idle cycles between doorbell reads (≥1).
- `BASE_ADDR`, 0: word address of the doorbell; descriptors start at `BASE_ADDR+1`.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset. **Asynchronous and active-high.**
- `bram_d_addr`, out, `ADDR_W`: word address.
- `bram_d_din`, out, 64: write data.
- `bram_d_dout`, in, 64: read data, valid the cycle after `en`.
- `bram_d_en`, out, 1: access enable.
- `bram_d_we`, out, 1: write enable, qualified by `en`.
- `cmd_valid`, out, 1: command valid.
- `cmd_ready`, in, 1: core accepts the command.
- `cmd_m`, `cmd_k`, `cmd_n`, out, `DIM_W` each: matrix dimensions.
- `cmd_last`, out, 1: marks the last descriptor of the batch.
- `core_done`, in, 1: one-cycle pulse when the core finishes a command.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- Doorbell word layout:
  - [15:0] descriptor count `cnt`.
  - [63] done flag.
  - All other bits are ignored on read.
- Descriptor word `i` (1-based) sits at `BASE_ADDR+i`:
  - [47:32] M, [31:16] K, [15:0] N; [63:48] reserved.
- FSM states:
  - IDLE: count `POLL_INTERVAL` cycles, then go to RD_DOOR.
  - RD_DOOR: issue the doorbell read, then go to WAIT_DOOR.
  - WAIT_DOOR: if `dout[63]==0` and `cnt!=0`, latch `cnt` and go to RD_DESC; otherwise go to IDLE.
  - RD_DESC: issue the descriptor read, then go to WAIT_DESC.
  - WAIT_DESC: latch M/K/N.
    - If any field is 0 or greater than `MAX_DIM`: increment the error count and advance.
    - Otherwise go to ISSUE.
  - ISSUE: hold `cmd_valid` until `cmd_valid&&cmd_ready`, then go to BUSY.
  - BUSY: wait for `core_done`, increment the executed count, then advance.
  - "Advance": go to RD_DESC if descriptors remain, else WR_STAT.
  - WR_STAT: one write cycle, then IDLE.
- Status word written in WR_STAT: {1'b1, 31'd0, err[15:0], exec[15:0]}.
- `cnt` is clamped to `2**ADDR_W-1-BASE_ADDR` so the descriptor address never wraps past the top of BRAM.
- `cmd_last` is high when the current descriptor index equals the clamped `cnt`. It is computed over all descriptors, including invalid ones.
- Invalid descriptors never assert `cmd_valid`.
- `core_done` outside BUSY is ignored.
- `cmd_ready` while `cmd_valid` is low has no effect.
- Asserting `rst` mid-batch: go immediately to IDLE, drop `cmd_valid`, write no status. The poll restarts from scratch, and the batch reruns because the doorbell is still uncleared.

## Timing
- Reset values: all outputs 0; poll counter 0; exec/err counters 0.
- BRAM read latency is 1 cycle: `en` is asserted in RD_*, and `dout` is sampled in WAIT_*.
- `bram_d_en` is high only in RD_DOOR, RD_DESC and WR_STAT. `bram_d_we` is high only in WR_STAT.
- `cmd_*` outputs are registered and held stable while `cmd_valid&&!cmd_ready`.
- A same-cycle `cmd_ready` is accepted the first cycle `cmd_valid` is high.
- `core_done` may arrive as early as the cycle after acceptance.
- Minimum per valid descriptor: 4 cycles (RD, WAIT, ISSUE with immediate ready, BUSY with immediate done).
- Minimum per invalid descriptor: 2 cycles.
- From the doorbell read to the first `cmd_valid`: 4 cycles.

## Structure
- Package `matrix_cmd_pkg` holds:
  - typedef `mm_desc_t` (packed M/K/N/reserved);
  - typedef `mm_status_t`;
  - the FSM state enum;
  - the doorbell bit positions and the `DONE_BIT=63` constant.
  - The multiply core imports `mm_desc_t` from this package.
- Single module; no sub-module is needed. The poll counter stays inline.

## Test plan
- Doorbell 64'd1, word1 `{16'd0,16'd8,16'd8,16'd8}`, ready tied high, `core_done` 3 cycles after acceptance → one command with M=K=N=8 and `cmd_last=1`. Word0 then becomes 64'h8000_0000_0000_0001 and `busy` drops.
- `cnt`=3 with descriptor 2 having K=0 → commands for descriptors 1 and 3 only, with `cmd_last` on descriptor 3. Status 64'h8000_0000_0001_0002.
- `cmd_ready` held low for 10 cycles → `cmd_valid` and `cmd_m/k/n` stay constant throughout, and exactly one acceptance occurs.
- Doorbell with bit 63 set, or with `cnt=0` → no commands and no writes. A doorbell read repeats every `POLL_INTERVAL+2` cycles.
- `rst` pulsed while in BUSY → all outputs 0 asynchronously and no status write. After release the batch reruns and completes normally.
- Spurious `core_done` while in IDLE or ISSUE → no change to the exec counter or the state.

Source files
------------

// File: rtl/matrix_cmd_pkg.sv
// Shared types for the matrix-multiply command path: descriptor and status word
// layouts, doorbell field positions and the fetch FSM states.
package matrix_cmd_pkg;

  localparam int DONE_BIT     = 63;
  localparam int DOOR_CNT_LSB = 0;
  localparam int DOOR_CNT_MSB = 15;

  typedef struct packed {
    logic [15:0] rsvd;
    logic [15:0] m;
    logic [15:0] k;
    logic [15:0] n;
  } mm_desc_t;

  typedef struct packed {
    logic        done;
    logic [30:0] rsvd;
    logic [15:0] err;
    logic [15:0] exec;
  } mm_status_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DOOR,
    ST_WAIT_DOOR,
    ST_RD_DESC,
    ST_WAIT_DESC,
    ST_ISSUE,
    ST_BUSY,
    ST_WR_STAT
  } mm_state_e;

  function automatic logic dim_ok(input logic [15:0] dim, input int max_dim);
    return (dim != 16'd0) && (int'({16'd0, dim}) <= max_dim);
  endfunction

endpackage

// File: rtl/matrix_cmd_fetch.sv
// Command front-end: polls the BRAM D doorbell, fetches and validates descriptors,
// issues one command per valid descriptor to the multiply core, writes back status.
module matrix_cmd_fetch
  import matrix_cmd_pkg::*;
#(
  parameter int ADDR_W        = 9,
  parameter int DIM_W         = 16,
  parameter int MAX_DIM       = 256,
  parameter int POLL_INTERVAL = 16,
  parameter int BASE_ADDR     = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] bram_d_addr,
  output logic [63:0]       bram_d_din,
  input  logic [63:0]       bram_d_dout,
  output logic              bram_d_en,
  output logic              bram_d_we,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [DIM_W-1:0]  cmd_m,
  output logic [DIM_W-1:0]  cmd_k,
  output logic [DIM_W-1:0]  cmd_n,
  output logic              cmd_last,
  input  logic              core_done,
  output logic              busy
);

  localparam int CNT_MAX = (2 ** ADDR_W) - 1 - BASE_ADDR;
  localparam int PW      = $clog2(POLL_INTERVAL) + 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);

  mm_state_e     state_reg, state_next;
  logic [PW-1:0] poll_cnt_reg;
  logic [15:0]   cnt_reg, idx_reg, exec_reg, err_reg;
  mm_desc_t      desc;
  mm_status_t    status;
  logic [15:0]   door_cnt, door_cnt_clamped;
  logic          door_go, desc_ok, more_desc, accept, unused_rsvd;

  assign desc      = mm_desc_t'(bram_d_dout);
  assign door_cnt  = bram_d_dout[DOOR_CNT_MSB:DOOR_CNT_LSB];
  assign door_go   = !bram_d_dout[DONE_BIT] && (door_cnt != 16'd0);
  // Clamp so BASE_ADDR+idx can never wrap past the top of the BRAM
  assign door_cnt_clamped = (int'({16'd0, door_cnt}) > CNT_MAX) ? 16'(CNT_MAX) : door_cnt;
  assign desc_ok   = dim_ok(desc.m, MAX_DIM) && dim_ok(desc.k, MAX_DIM) && dim_ok(desc.n, MAX_DIM);
  assign more_desc = (idx_reg != cnt_reg);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_reg != ST_IDLE);
  assign unused_rsvd = ^desc.rsvd;
  assign status    = '{done: 1'b1, rsvd: 31'd0, err: err_reg, exec: exec_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    bram_d_en   = 1'b0;
    bram_d_we   = 1'b0;
    bram_d_addr = '0;
    bram_d_din  = '0;
    case (state_reg)
      ST_IDLE: if (poll_cnt_reg == POLL_LAST) state_next = ST_RD_DOOR;
      ST_RD_DOOR: begin
        bram_d_en   = 1'b1;
        bram_d_addr = ADDR_W'(BASE_ADDR);
        state_next  = ST_WAIT_DOOR;
      end
      ST_WAIT_DOOR: state_next = door_go ? ST_RD_DESC : ST_IDLE;
      ST_RD_DESC: begin
        bram_d_en   = 1'b1;
        bram_d_addr = ADDR_W'(BASE_ADDR + int'(idx_reg));
        state_next  = ST_WAIT_DESC;
      end
      ST_WAIT_DESC: begin
        if (desc_ok)        state_next = ST_ISSUE;
        else if (more_desc) state_next = ST_RD_DESC;
        else                state_next = ST_WR_STAT;
      end
      ST_ISSUE: if (accept) state_next = ST_BUSY;
      ST_BUSY:  if (core_done) state_next = more_desc ? ST_RD_DESC : ST_WR_STAT;
      ST_WR_STAT: begin
        bram_d_en   = 1'b1;
        bram_d_we   = 1'b1;
        bram_d_addr = ADDR_W'(BASE_ADDR);
        bram_d_din  = status;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt_reg <= '0;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      exec_reg     <= '0;
      err_reg      <= '0;
      cmd_valid    <= 1'b0;
      cmd_m        <= '0;
      cmd_k        <= '0;
      cmd_n        <= '0;
      cmd_last     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: poll_cnt_reg <= (poll_cnt_reg == POLL_LAST) ? '0 : poll_cnt_reg + 1'b1;
        ST_WAIT_DOOR: begin
          if (door_go) begin
            cnt_reg  <= door_cnt_clamped;
            idx_reg  <= 16'd1;
            exec_reg <= '0;
            err_reg  <= '0;
          end
        end
        ST_WAIT_DESC: begin
          cmd_m    <= DIM_W'(desc.m);
          cmd_k    <= DIM_W'(desc.k);
          cmd_n    <= DIM_W'(desc.n);
          cmd_last <= !more_desc;
          if (desc_ok) begin
            cmd_valid <= 1'b1;
          end else begin
            err_reg <= err_reg + 16'd1;
            if (more_desc) idx_reg <= idx_reg + 16'd1;
          end
        end
        ST_ISSUE: if (accept) cmd_valid <= 1'b0;
        // Done pulses outside BUSY fall through to default and are ignored
        ST_BUSY: begin
          if (core_done) begin
            exec_reg <= exec_reg + 16'd1;
            if (more_desc) idx_reg <= idx_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_cmd_fetch.sv
// Randomized self-checking bench for matrix_cmd_fetch: BRAM D model, core responder
// and a batch-level reference model computed from the memory image.
module tb_matrix_cmd_fetch;

  localparam int AW     = 9;
  localparam int DW     = 16;
  localparam int MAXD   = 256;
  localparam int P      = 4;
  localparam int BASE   = 0;
  localparam int NWORDS = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] bram_d_addr;
  logic [63:0]   bram_d_din, bram_d_dout;
  logic          bram_d_en, bram_d_we;
  logic          cmd_valid, cmd_ready, cmd_last, core_done, busy;
  logic [DW-1:0] cmd_m, cmd_k, cmd_n;

  matrix_cmd_fetch #(
    .ADDR_W(AW), .DIM_W(DW), .MAX_DIM(MAXD), .POLL_INTERVAL(P), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .bram_d_addr(bram_d_addr), .bram_d_din(bram_d_din), .bram_d_dout(bram_d_dout),
    .bram_d_en(bram_d_en), .bram_d_we(bram_d_we),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m(cmd_m), .cmd_k(cmd_k), .cmd_n(cmd_n), .cmd_last(cmd_last),
    .core_done(core_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // BRAM D with a bench-side load port used only while the DUT is held in reset
  logic [63:0]   mem [NWORDS];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [63:0]   tb_wdata = '0;
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (bram_d_en) begin
      if (bram_d_we) mem[bram_d_addr] <= bram_d_din;
      bram_d_dout <= mem[bram_d_addr];
    end
  end

  logic [63:0] ref_mem [NWORDS];
  logic [48:0] exp_q[$];
  logic [48:0] obs_q[$];
  logic [63:0] exp_status;
  bit          exp_batch;
  int          checks = 0, errors = 0;
  int          wr_count = 0, desc_rd_count = 0, cyc = 0, last_door = 0, first_lat = -1;
  bit          lat_armed = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;
  int          door_t[$];
  int          hold_viol = 0;
  int          ready_mode = 0, done_lo = 0, done_hi = 0;
  bit          spur_en = 0;

  // Bus monitor
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bram_d_en && bram_d_we) begin
        wr_count++;
        last_wr_addr = bram_d_addr;
        last_wr_data = bram_d_din;
      end else if (bram_d_en) begin
        if (bram_d_addr == AW'(BASE)) begin
          door_t.push_back(cyc);
          last_door = cyc;
          lat_armed = 1;
        end else desc_rd_count++;
      end
      if (cmd_valid && !prev_valid && lat_armed) begin
        first_lat = cyc - last_door;
        lat_armed = 0;
      end
      prev_valid = cmd_valid;
    end
  end

  // Multiply-core responder
  initial begin
    int pend, hold_left;
    logic pv, pr, pl;
    logic [47:0] pcmd;
    pend = -1; hold_left = 10; pv = 0; pr = 0; pl = 0; pcmd = '0;
    cmd_ready = 1'b0;
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst) begin
        pend = -1; hold_left = 10; cmd_ready = 1'b0; pv = 0; pr = 0;
      end else begin
        if (pv && !pr && (!cmd_valid || {cmd_m, cmd_k, cmd_n} != pcmd || cmd_last != pl))
          hold_viol++;
        if (pend == 0) begin
          core_done = 1'b1;
          pend = -1;
        end else if (pend > 0) pend--;
        else if (spur_en && $urandom_range(3) == 0) core_done = 1'b1;
        case (ready_mode)
          0: cmd_ready = 1'b1;
          1: cmd_ready = ($urandom_range(2) == 0);
          default: begin
            if (cmd_valid && hold_left > 0) begin
              cmd_ready = 1'b0;
              hold_left--;
            end else cmd_ready = 1'b1;
          end
        endcase
        if (cmd_valid && cmd_ready) begin
          obs_q.push_back({cmd_last, cmd_m, cmd_k, cmd_n});
          pend = int'($urandom_range(done_hi, done_lo));
          hold_left = 10;
        end
        pv = cmd_valid; pr = cmd_ready; pl = cmd_last; pcmd = {cmd_m, cmd_k, cmd_n};
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic mem_wr(input int a, input logic [63:0] d);
    ref_mem[a] = d;
    tb_addr    = AW'(a);
    tb_wdata   = d;
    tb_we      = 1'b1;
    tick();
    tb_we      = 1'b0;
  endtask

  function automatic logic [15:0] rand_dim();
    int r;
    r = int'($urandom_range(9));
    case (r)
      0: return 16'd0;
      1: return 16'd1;
      2: return 16'(MAXD);
      3: return 16'(MAXD + 1);
      4: return 16'hFFFF;
      default: return 16'($urandom_range(MAXD, 1));
    endcase
  endfunction

  function automatic logic [63:0] rand_desc();
    return {16'($urandom), rand_dim(), rand_dim(), rand_dim()};
  endfunction

  // Reference: expected accepted-command list and status word from the memory image
  task automatic build_expect();
    logic [63:0] door, d;
    logic [15:0] m, k, n;
    int cnt, lim, nerr, nexec;
    exp_q.delete();
    door      = ref_mem[BASE];
    cnt       = int'(door[15:0]);
    exp_batch = !door[63] && cnt != 0;
    exp_status = '0;
    if (!exp_batch) return;
    lim = NWORDS - 1 - BASE;
    if (cnt > lim) cnt = lim;
    nerr = 0;
    nexec = 0;
    for (int i = 1; i <= cnt; i++) begin
      d = ref_mem[BASE + i];
      m = d[47:32]; k = d[31:16]; n = d[15:0];
      if (m >= 1 && m <= MAXD && k >= 1 && k <= MAXD && n >= 1 && n <= MAXD) begin
        exp_q.push_back({(i == cnt), m, k, n});
        nexec++;
      end else nerr++;
    end
    exp_status = {1'b1, 31'd0, 16'(nerr), 16'(nexec)};
  endtask

  task automatic run_batch(input string tag);
    int ob, w0, n;
    bit to;
    build_expect();
    ob = obs_q.size();
    w0 = wr_count;
    rst = 1'b0;
    n = 0;
    while (wr_count == w0 && n < 30000) begin
      tick();
      n++;
    end
    to = (wr_count == w0);
    check_val({tag, "_timeout"}, 64'(to), 64'd0);
    if (!to) begin
      check_val({tag, "_busy_in_wr"}, 64'(busy), 64'd1);
      check_val({tag, "_stat_addr"}, 64'(last_wr_addr), 64'(BASE));
      check_val({tag, "_stat_data"}, last_wr_data, exp_status);
      tick();
      check_val({tag, "_busy_after"}, 64'(busy), 64'd0);
      check_val({tag, "_nwrites"}, 64'(wr_count - w0), 64'd1);
    end
    check_val({tag, "_ncmd"}, 64'(obs_q.size() - ob), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++)
      check_val($sformatf("%s_cmd%0d", tag, i), 64'(obs_q[ob + i]), 64'(exp_q[i]));
    $display("batch %s: cmds=%0d expected=%0d status=0x%h", tag, obs_q.size() - ob,
             exp_q.size(), last_wr_data);
    rst = 1'b1;
    tick();
  endtask

  task automatic idle_run(input string tag, input logic [63:0] door);
    int ob, w0, b;
    mem_wr(BASE, door);
    ob = obs_q.size();
    w0 = wr_count;
    b  = door_t.size();
    rst = 1'b0;
    for (int i = 0; i < 3 * (P + 2) + P + 4; i++) tick();
    check_val({tag, "_no_cmd"}, 64'(obs_q.size() - ob), 64'd0);
    check_val({tag, "_no_write"}, 64'(wr_count - w0), 64'd0);
    check_val({tag, "_nreads_ge3"}, 64'(door_t.size() - b >= 3), 64'd1);
    if (door_t.size() - b >= 3) begin
      check_val({tag, "_poll_gap0"}, 64'(door_t[b + 1] - door_t[b]), 64'(P + 2));
      check_val({tag, "_poll_gap1"}, 64'(door_t[b + 2] - door_t[b + 1]), 64'(P + 2));
    end
    $display("idle %s: doorbell reads=%0d", tag, door_t.size() - b);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int w0, ob, n, rd0;
    rst = 1'b1;
    repeat (3) tick();
    check_val("reset_ctrl", 64'({busy, cmd_valid, cmd_last, bram_d_en, bram_d_we}), 64'd0);
    check_val("reset_din", bram_d_din, 64'd0);
    check_val("reset_addr_dims", 64'({bram_d_addr, cmd_m, cmd_k, cmd_n}), 64'd0);

    // Single descriptor, ready tied high, done three cycles after acceptance
    ready_mode = 0; spur_en = 0; done_lo = 2; done_hi = 2;
    mem_wr(BASE + 1, {16'd0, 16'd8, 16'd8, 16'd8});
    mem_wr(BASE, 64'd1);
    run_batch("t1");
    check_val("t1_word0", mem[BASE], 64'h8000_0000_0000_0001);
    check_val("t1_door_to_valid", 64'(first_lat), 64'd4);

    // Middle descriptor invalid (K=0)
    done_lo = 0; done_hi = 0;
    mem_wr(BASE + 1, {16'd0, 16'd4, 16'd5, 16'd6});
    mem_wr(BASE + 2, {16'd0, 16'd4, 16'd0, 16'd4});
    mem_wr(BASE + 3, {16'd0, 16'd1, 16'd2, 16'd3});
    mem_wr(BASE, 64'd3);
    run_batch("t2");
    check_val("t2_status_const", last_wr_data, 64'h8000_0000_0001_0002);

    // Back-pressure: ready held low for ten valid cycles per command
    ready_mode = 2; done_lo = 1; done_hi = 1;
    n = hold_viol;
    mem_wr(BASE + 1, {16'd0, 16'd100, 16'd200, 16'd3});
    mem_wr(BASE + 2, {16'hABCD, 16'd256, 16'd1, 16'd256});
    mem_wr(BASE, 64'd2);
    run_batch("t3");
    check_val("t3_hold_stable", 64'(hold_viol - n), 64'd0);

    // Doorbell done flag set, and zero count: poll only
    ready_mode = 0;
    idle_run("t4_doneflag", 64'h8000_0000_0000_0003);
    idle_run("t5_cnt0", 64'h0123_4567_89AB_0000);

    // Reset while the core is busy, then rerun the batch
    done_lo = 5; done_hi = 5;
    mem_wr(BASE + 1, {16'd0, 16'd7, 16'd9, 16'd11});
    mem_wr(BASE + 2, {16'd0, 16'd2, 16'd2, 16'd2});
    mem_wr(BASE + 3, {16'd0, 16'd3, 16'd3, 16'd3});
    mem_wr(BASE, 64'd3);
    w0 = wr_count;
    ob = obs_q.size();
    rst = 1'b0;
    n = 0;
    while (obs_q.size() == ob && n < 1000) begin
      tick();
      n++;
    end
    check_val("t6_reached_issue", 64'(obs_q.size() > ob), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_rst_ctrl", 64'({busy, cmd_valid, cmd_last, bram_d_en, bram_d_we}), 64'd0);
    check_val("t6_rst_dims", 64'({cmd_m, cmd_k, cmd_n}), 64'd0);
    tick();
    tick();
    check_val("t6_no_status", 64'(wr_count - w0), 64'd0);
    run_batch("t6_rerun");

    // Random batches with random back-pressure, done delay and spurious done pulses
    ready_mode = 1; spur_en = 1; done_lo = 0; done_hi = 4;
    for (int b = 0; b < 8; b++) begin
      int cnt;
      cnt = int'($urandom_range(8, 1));
      for (int i = 1; i <= cnt; i++) mem_wr(BASE + i, rand_desc());
      mem_wr(BASE, {1'b0, 15'($urandom), 32'($urandom), 16'(cnt)});
      run_batch($sformatf("rnd%0d", b));
    end

    // Count far beyond the BRAM: clamped so descriptor reads stop at the top word
    for (int i = 1; i < NWORDS; i++) mem_wr(BASE + i, rand_desc());
    mem_wr(BASE, {1'b0, 47'd0, 16'hFFFF});
    rd0 = desc_rd_count;
    run_batch("clamp");
    check_val("clamp_desc_reads", 64'(desc_rd_count - rd0), 64'(NWORDS - 1 - BASE));

    check_val("hold_stable_all", 64'(hold_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
